// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Brief    : Debounced one-hot keypad entry. Each accepted key press is
//            emitted once as a BCD digit with a one-cycle load strobe and is
//            shifted into a three-digit preview. Simultaneous multi-key
//            presses are rejected with a one-cycle err pulse.
// Build    : KEYPAD_DEBOUNCE_EN - when defined, a press must be stable for
//            DEBOUNCE_CYCLES cycles before it is accepted; when undefined,
//            the debounce stage and its counter are compiled out.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] keys,
    input  logic       lock,
    output logic [3:0] data,
    output logic       load,
    output logic [3:0] ent0,
    output logic [3:0] ent1,
    output logic [3:0] ent2,
    output logic [1:0] count,
    output logic       err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_EMIT     = 2'd2;
    localparam logic [1:0] c_RELEASE  = 2'd3;

    logic [1:0] r_state;
    logic [9:0] r_sample;
    logic [3:0] r_data;
    logic       r_load;
    logic       r_err;
    logic [3:0] r_ent0;
    logic [3:0] r_ent1;
    logic [3:0] r_ent2;
    logic [1:0] r_count;

    logic       w_any;
    logic       w_multi;
    logic       w_onehot;
    logic [3:0] w_index;

    // x & (x-1) clears the lowest set bit, so any remaining bit means two or more keys
    assign w_any    = |keys;
    assign w_multi  = |(keys & (keys - 10'd1));
    assign w_onehot = w_any & ~w_multi;

    // Binary index of the captured key; the sample is always one-hot, so 0-9 only
    always_comb begin
        w_index = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_sample[i]) begin
                w_index = 4'(i);
            end
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int c_DEB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int c_CW  = (c_DEB > 1) ? $clog2(c_DEB) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_DEB - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_same;
    logic            w_deb_done;

    assign w_same     = (keys == r_sample);
    assign w_deb_done = (r_cnt == c_LAST);

    // Stability counter: advances only while the captured key is still held, else clears
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_cnt <= '0;
        end else if ((r_state == c_DEBOUNCE) && !lock && w_same && !w_deb_done) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    // Debounce length has no effect in this build; the parameter stays so
    // instantiations are identical whichever way the block is built.
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_unused
    end
`endif

    // Entry FSM plus registered outputs; load/err default low so they only pulse
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_state  <= c_IDLE;
            r_sample <= '0;
            r_data   <= 4'd0;
            r_load   <= 1'b0;
            r_err    <= 1'b0;
            r_ent0   <= 4'd0;
            r_ent1   <= 4'd0;
            r_ent2   <= 4'd0;
            r_count  <= 2'd0;
        end else begin
            r_load <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (lock) begin
                        r_state <= c_RELEASE;
                    end else if (w_onehot) begin
                        r_sample <= keys;
`ifdef KEYPAD_DEBOUNCE_EN
                        r_state  <= c_DEBOUNCE;
`else
                        r_state  <= c_EMIT;
`endif
                    end else if (w_multi) begin
                        r_err   <= 1'b1;
                        r_state <= c_RELEASE;
                    end
                end
                c_DEBOUNCE: begin
`ifdef KEYPAD_DEBOUNCE_EN
                    if (lock) begin
                        r_state <= c_RELEASE;
                    end else if (!w_same) begin
                        r_state <= c_IDLE;
                    end else if (w_deb_done) begin
                        r_state <= c_EMIT;
                    end
`else
                    r_state <= c_IDLE;
`endif
                end
                c_EMIT: begin
                    // A lock arriving now does not cancel the digit already accepted
                    r_load  <= 1'b1;
                    r_data  <= w_index;
                    r_ent2  <= r_ent1;
                    r_ent1  <= r_ent0;
                    r_ent0  <= w_index;
                    if (r_count != 2'd3) begin
                        r_count <= r_count + 2'd1;
                    end
                    r_state <= c_RELEASE;
                end
                default: begin
                    // Wait for all keys up, so a held key cannot emit twice
                    if (!lock && !w_any) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign data  = r_data;
    assign load  = r_load;
    assign err   = r_err;
    assign ent0  = r_ent0;
    assign ent1  = r_ent1;
    assign ent2  = r_ent2;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Brief    : Self-checking bench for keypad_entry. Expected digits, previews
//            and err pulses are queued as stimulus is driven and compared
//            when the design strobes load or err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

    localparam int c_DEB = 4;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int c_LAT = c_DEB + 1;
`else
    localparam int c_LAT = 1;
`endif

    typedef struct packed {
        logic       is_err;
        logic [3:0] d;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [1:0] c;
    } exp_t;

    typedef struct {
        logic [9:0] k;
        int         hold;
    } vec_t;

    logic       clk;
    logic       clearn;
    logic [9:0] keys;
    logic       lock;
    logic [3:0] data;
    logic       load;
    logic [3:0] ent0;
    logic [3:0] ent1;
    logic [3:0] ent2;
    logic [1:0] count;
    logic       err;

    int   n_vec;
    int   n_fail;
    int   n_load;
    int   n_err;
    exp_t q[$];
    exp_t m_e;
    logic [3:0] m0, m1, m2;
    logic [1:0] mc;

    keypad_entry #(.DEBOUNCE_CYCLES(c_DEB)) dut (
        .clk    (clk),
        .clearn (clearn),
        .keys   (keys),
        .lock   (lock),
        .data   (data),
        .load   (load),
        .ent0   (ent0),
        .ent1   (ent1),
        .ent2   (ent2),
        .count  (count),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic void expect_load(input logic [3:0] d);
        exp_t e;
        m2 = m1;
        m1 = m0;
        m0 = d;
        if (mc != 2'd3) mc = mc + 2'd1;
        e    = '0;
        e.d  = d;
        e.e0 = m0;
        e.e1 = m1;
        e.e2 = m2;
        e.c  = mc;
        q.push_back(e);
    endfunction

    function automatic void expect_err();
        exp_t e;
        e        = '0;
        e.is_err = 1'b1;
        q.push_back(e);
    endfunction

    // Model decides the outcome of a simple press, then drives it and lets the FSM settle
    task automatic press(input logic [9:0] k, input int hold);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) if (k[i]) d = 4'(i);
        if ($countones(k) > 1) expect_err();
        else if ($countones(k) == 1 && hold >= c_LAT) expect_load(d);
        @(posedge clk); #1;
        keys = k;
        repeat (hold) @(posedge clk);
        #1;
        keys = 10'h000;
        repeat (4) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    // Scoreboard: every load/err strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (load) n_load++;
        if (err)  n_err++;
        if (load && err) begin
            n_vec++;
            n_fail++;
            $display("FAIL load_err_overlap: got load=1 err=1, want at most one");
        end else if (load || err) begin
            n_vec++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got load=%0b err=%0b data=%0d, want none", load, err, data);
            end else begin
                m_e = q.pop_front();
                if (load && (m_e.is_err || data !== m_e.d || ent0 !== m_e.e0 ||
                             ent1 !== m_e.e1 || ent2 !== m_e.e2 || count !== m_e.c)) begin
                    n_fail++;
                    $display("FAIL load: got err_exp=%0b data=%0d ent=%0d,%0d,%0d count=%0d, want data=%0d ent=%0d,%0d,%0d count=%0d",
                             m_e.is_err, data, ent2, ent1, ent0, count, m_e.d, m_e.e2, m_e.e1, m_e.e0, m_e.c);
                end else if (err && !m_e.is_err) begin
                    n_fail++;
                    $display("FAIL err: got err pulse, want load data=%0d", m_e.d);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(data),  0);
        check({tag, "_load"},  32'(load),  0);
        check({tag, "_err"},   32'(err),   0);
        check({tag, "_ent0"},  32'(ent0),  0);
        check({tag, "_ent1"},  32'(ent1),  0);
        check({tag, "_ent2"},  32'(ent2),  0);
        check({tag, "_count"}, 32'(count), 0);
    endtask

    initial begin
        vec_t tbl[11];
        int   lat;
        int   base_l;
        int   base_e;

        tbl[0]  = '{k: 10'h002, hold: c_LAT + 1};
        tbl[1]  = '{k: 10'h004, hold: c_LAT + 1};
        tbl[2]  = '{k: 10'h020, hold: c_LAT + 1};
        tbl[3]  = '{k: 10'h200, hold: c_LAT + 1};
        tbl[4]  = '{k: 10'h040, hold: 2};
        tbl[5]  = '{k: 10'h080, hold: c_LAT};
        tbl[6]  = '{k: 10'h100, hold: c_LAT - 1};
        tbl[7]  = '{k: 10'h011, hold: 3};
        tbl[8]  = '{k: 10'h001, hold: c_LAT + 3};
        tbl[9]  = '{k: 10'h300, hold: 2};
        tbl[10] = '{k: 10'h010, hold: c_LAT + 1};

        n_vec = 0; n_fail = 0; n_load = 0; n_err = 0;
        m0 = 4'd0; m1 = 4'd0; m2 = 4'd0; mc = 2'd0;
        clearn = 1'b0; keys = 10'h000; lock = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        clearn = 1'b1;
        repeat (2) @(posedge clk);

        // Held key: one load, digit 3, at the expected latency
        base_l = n_load;
        expect_load(4'd3);
        @(posedge clk); #1;
        keys = 10'h008;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            if (load && lat < 0) lat = k;
        end
        keys = 10'h000;
        repeat (4) @(posedge clk);
        #1;
        check("held_latency", lat, c_LAT);
        check("held_one_load", n_load - base_l, 1);
        check("held_ent0", 32'(ent0), 3);
        check("held_count", 32'(count), 1);
        check("held_drain", q.size(), 0);

        // Digit sequence 1,2,5 then 9 shifts the preview and saturates count
        press(10'h002, c_LAT + 1);
        press(10'h004, c_LAT + 1);
        press(10'h020, c_LAT + 1);
        check("seq_ent2", 32'(ent2), 1);
        check("seq_ent1", 32'(ent1), 2);
        check("seq_ent0", 32'(ent0), 5);
        check("seq_count", 32'(count), 3);
        press(10'h200, c_LAT + 1);
        check("sat_ent2", 32'(ent2), 2);
        check("sat_ent1", 32'(ent1), 5);
        check("sat_ent0", 32'(ent0), 9);
        check("sat_count", 32'(count), 3);

        // Table of single presses, bounces, boundary holds and multi-key presses
        for (int i = 0; i < 11; i++) press(tbl[i].k, tbl[i].hold);

        // Multi-key: err, then stay in release even when it narrows to one key
        base_l = n_load;
        base_e = n_err;
        expect_err();
        @(posedge clk); #1;
        keys = 10'h011;
        repeat (2) @(posedge clk);
        #1;
        keys = 10'h001;
        repeat (10) @(posedge clk);
        #1;
        check("multi_no_load", n_load - base_l, 0);
        check("multi_one_err", n_err - base_e, 1);
        keys = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        check("multi_drain", q.size(), 0);
        press(10'h001, c_LAT + 1);

        // Lock held with key down, then lock drops while key still held
        base_l = n_load;
        @(posedge clk); #1;
        lock = 1'b1;
        keys = 10'h200;
        repeat (10) @(posedge clk);
        #1;
        check("lock_no_load", n_load - base_l, 0);
        lock = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("unlock_held_no_load", n_load - base_l, 0);
        keys = 10'h000;
        repeat (3) @(posedge clk);
        press(10'h200, c_LAT + 1);
        check("relock_one_load", n_load - base_l, 1);

        // Reset landing on the EMIT cycle suppresses the load
        base_l = n_load;
        @(posedge clk); #1;
        keys = 10'h002;
        @(posedge clk);
        repeat (c_LAT - 1) @(posedge clk);
        #1;
        clearn = 1'b0;
        @(posedge clk); #1;
        check_all_zero("emit_reset");
        keys = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("hold_reset");
        check("emit_reset_no_load", n_load - base_l, 0);
        m0 = 4'd0; m1 = 4'd0; m2 = 4'd0; mc = 2'd0;
        clearn = 1'b1;
        repeat (2) @(posedge clk);

        // Back in service after reset
        press(10'h080, c_LAT + 1);
        check("post_reset_ent0", 32'(ent0), 7);
        check("post_reset_ent1", 32'(ent1), 0);
        check("post_reset_count", 32'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
